apb_bridge_master: RTL and testbench
====================================

# apb_bridge_master

APB initiator that turns single-word read/write commands from the encoder/decoder control path into APB3 transfers toward the register-selector slave and any other APB peripheral. Accepts one command at a time over a valid/ready interface, runs the SETUP/ACCESS sequence, waits on PREADY, and returns a one-cycle response pulse with read data. Sits between the local control FSM (or test host) and the APB fabric.

## Interface
- AMBA_ADDR_WIDTH, 20, PADDR / command address width
- AMBA_WORD, 32, data width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with APB_TIMEOUT_EN); legal range ≥ 2
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  AMBA_ADDR_WIDTH  target address
- cmd_wdata  input  AMBA_WORD  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  AMBA_WORD  read data (0 for writes and timeouts)
- rsp_timeout  output  1  qualifies rsp_valid: transfer aborted
- PADDR  output  AMBA_ADDR_WIDTH  APB address
- PWDATA  output  AMBA_WORD  APB write data
- PWRITE  output  1  APB direction
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PRDATA  input  AMBA_WORD  APB read data
- PREADY  input  1  APB ready; tie high for zero-wait slaves

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = 1 (combinational, forced 0 while rst). On handshake: latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. On PREADY=1: capture PRDATA into rsp_rdata (reads), 0 for writes; rsp_valid=1 next cycle; go IDLE.
- PADDR/PWDATA/PWRITE stable from SETUP through the last ACCESS cycle; hold last values in IDLE.
- No response backpressure: consumer must take rsp_valid when it pulses.
- Slaves with registered read data (PRDATA updated on the edge sampling PSEL&PENABLE) must hold PREADY low for the first ACCESS cycle; the master samples PRDATA only on the PREADY=1 edge.
- Reset (any state, including mid-transfer): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_timeout all 0; timeout counter 0. An aborted transfer produces no response.

## Timing
- Zero-wait transfer: accept edge T0 → SETUP in T0+1 → ACCESS in T0+2 → rsp_valid and cmd_ready=1 in T0+3.
- Minimum command spacing 3 cycles; a command presented while rsp_valid is high is accepted that same cycle.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- rsp_valid high for exactly one cycle per completed or aborted transfer.

## Configuration
- APB_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYCLES+1) increments per ACCESS cycle with PREADY=0, clears on entering SETUP. If PREADY=0 on the TIMEOUT_CYCLES-th ACCESS cycle: go IDLE, PSEL/PENABLE drop next cycle, rsp_valid=1, rsp_timeout=1, rsp_rdata=0. PREADY=1 on that cycle completes normally (completion wins).
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_timeout tied 0; TIMEOUT_CYCLES ignored.

## Test plan
- Write cmd_addr=0x00004, cmd_wdata=0xDEADBEEF, PREADY=1 → PSEL rises T0+1, PENABLE T0+2, PADDR=0x00004, PWDATA=0xDEADBEEF, PWRITE=1; rsp_valid=1, rsp_rdata=0 at T0+3.
- Read 0x00008 with PREADY low 1 cycle, PRDATA=0x12345678 when PREADY=1 → ACCESS lasts 2 cycles, rsp_rdata=0x12345678 at T0+4.
- Back-to-back: write then read held on cmd_valid → second accept coincides with first rsp_valid; PSEL low exactly one cycle between transfers.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY=0 → ACCESS exactly 4 cycles, rsp_valid=1 with rsp_timeout=1, rsp_rdata=0; PREADY rising on 4th cycle instead → normal completion, rsp_timeout=0.
- rst=1 during ACCESS of a read → next cycle PSEL=PENABLE=0, all outputs 0, no rsp_valid; new command after rst=0 completes normally.
- Without APB_TIMEOUT_EN, PREADY=0 for 100 cycles then 1 → single completion, rsp_timeout never asserted.

Source files
------------

// File: rtl/apb_bridge_master.sv
// APB3 initiator: one valid/ready command at a time becomes a SETUP/ACCESS transfer,
// and completion is signalled by a one-cycle response pulse. Define APB_TIMEOUT_EN to enable the ACCESS timeout.
module apb_bridge_master #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_timeout,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PWRITE,
  output logic                       PSEL,
  output logic                       PENABLE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_bridge_master: TIMEOUT_CYCLES must be at least 2");
  end

  // Ready is combinational so a new command can be taken in the same cycle as rsp_valid.
  assign cmd_ready = (state == IDLE) && !rst;

`ifdef APB_TIMEOUT_EN
  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
`ifdef APB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
            // wait_cnt counts earlier stalled cycles, so this is the last allowed one.
            if (wait_cnt == LAST_WAIT) begin
              rsp_valid   <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
              PSEL        <= 1'b0;
              PENABLE     <= 1'b0;
              state       <= IDLE;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_master.sv
// Self-checking bench for apb_bridge_master: a timeline model of each transfer against a memory-backed APB slave.
module tb_apb_bridge_master;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  apb_bridge_master #(
    .AMBA_ADDR_WIDTH(AW),
    .AMBA_WORD      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},    32'(PSEL),      32'd0);
    check({tag, "_penable"}, 32'(PENABLE),   32'd0);
    check({tag, "_pwrite"},  32'(PWRITE),    32'd0);
    check({tag, "_paddr"},   32'(PADDR),     32'd0);
    check({tag, "_pwdata"},  PWDATA,         32'd0);
    check({tag, "_rvalid"},  32'(rsp_valid), 32'd0);
    check({tag, "_rdata"},   rsp_rdata,      32'd0);
    check({tag, "_rto"},     32'(rsp_timeout), 32'd0);
  endtask

  // One transfer: accept on the next edge, SETUP for one cycle, ACCESS for waits+1 cycles
  // (or TO cycles when the timeout fires), then the response cycle. Returns at the response cycle.
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int waits);
    logic [DW-1:0] rd;
    logic [DW-1:0] drive;
    bit            to;
    int            n_acc;
    to    = TO_EN && (waits >= TO);
    n_acc = to ? TO : waits + 1;
    rd    = mem.exists(a) ? mem[a] : $urandom;
    drive = wr ? $urandom : rd;

    check("idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;

    check("setup_psel",    32'(PSEL),      32'd1);
    check("setup_penable", 32'(PENABLE),   32'd0);
    check("setup_paddr",   32'(PADDR),     32'(a));
    check("setup_pwdata",  PWDATA,         d);
    check("setup_pwrite",  32'(PWRITE),    32'(wr));
    check("setup_ready",   32'(cmd_ready), 32'd0);
    check("setup_rvalid",  32'(rsp_valid), 32'd0);

    for (int i = 0; i < n_acc; i++) begin
      @(negedge clk);
      check("acc_psel",    32'(PSEL),      32'd1);
      check("acc_penable", 32'(PENABLE),   32'd1);
      check("acc_paddr",   32'(PADDR),     32'(a));
      check("acc_pwdata",  PWDATA,         d);
      check("acc_pwrite",  32'(PWRITE),    32'(wr));
      check("acc_rvalid",  32'(rsp_valid), 32'd0);
      PREADY = !to && (i == n_acc - 1);
      PRDATA = PREADY ? drive : $urandom;
    end

    @(negedge clk);
    PREADY = 1'b0;
    PRDATA = $urandom;
    check("rsp_valid",   32'(rsp_valid),   32'd1);
    check("rsp_timeout", 32'(rsp_timeout), 32'(to));
    check("rsp_rdata",   rsp_rdata,        (to || wr) ? 32'd0 : rd);
    check("rsp_psel",    32'(PSEL),        32'd0);
    check("rsp_penable", 32'(PENABLE),     32'd0);
    check("rsp_ready",   32'(cmd_ready),   32'd1);
    if (wr && !to) mem[a] = d;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_rvalid", 32'(rsp_valid), 32'd0);
    check("idle_psel",   32'(PSEL),      32'd0);
    check("idle_ready",  32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(cmd_ready), 32'd1);

    // Directed zero-wait write, then a read with one stall cycle.
    xfer(1'b1, 20'h00004, 32'hDEADBEEF, 0);
    idle_cycle();
    mem[20'h00008] = 32'h12345678;
    xfer(1'b0, 20'h00008, 32'h0, 1);
    idle_cycle();

    // Back-to-back: the read is presented during the write's response cycle.
    xfer(1'b1, 20'h00010, 32'hA5A5_0001, 0);
    xfer(1'b0, 20'h00010, 32'h0, 0);
    idle_cycle();

`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 20'h00020, 32'h0, 50);
    idle_cycle();
    xfer(1'b0, 20'h00004, 32'h0, TO - 1);
    idle_cycle();
`else
    xfer(1'b0, 20'h00004, 32'h0, 100);
    idle_cycle();
`endif

    // Reset during the ACCESS phase of a read aborts it without a response.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 20'h00030;
    cmd_wdata = 32'h1111_2222;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_in_access", 32'(PENABLE), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    check("mid_reset_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_abort");
    check("after_abort_ready", 32'(cmd_ready), 32'd1);
    xfer(1'b0, 20'h00004, 32'h0, 0);
    idle_cycle();

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 24; n++) begin
      xfer(1'($urandom), AW'($urandom_range(0, 7) * 4), $urandom, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
